// File: rtl/dsp_mac_sequencer.sv
// Sequencer that runs one DSP48A1 slice as a signed multiply-accumulate engine:
// streams operand pairs into A/B, issues pipeline-aligned OPMODE codes, drains and captures P.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int OPM_DLY = 1,
  parameter int P_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [17:0]       s_a,
  input  logic [17:0]       s_b,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  input  logic [47:0]       dsp_p,
  output logic [47:0]       result,
  output logic              result_valid
);

  localparam logic [7:0] OPM_IDLE  = 8'h00;
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P
  localparam int         DRN_W     = $clog2(P_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             first_flag;
  logic [DRN_W-1:0] drain_cnt;
  logic [7:0]       opm_line_in;
  logic [7:0]       opm_pipe [0:OPM_DLY];
  logic             beat;
  logic             drain_last;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    opm_line_in = OPM_IDLE;
    s_ready     = 1'b0;
    dsp_ce      = 1'b0;
    beat        = 1'b0;
    drain_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (len != '0)) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        s_ready     = 1'b1;
        dsp_ce      = 1'b1;
        beat        = s_valid;
        opm_line_in = beat ? (first_flag ? OPM_FIRST : OPM_ACC) : OPM_HOLD;
        if (beat && (remaining == LEN_W'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        dsp_ce      = 1'b1;
        opm_line_in = OPM_HOLD;
        if (drain_cnt == DRN_W'(1)) begin
          drain_last = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      remaining    <= '0;
      first_flag   <= 1'b0;
      drain_cnt    <= '0;
      dsp_a        <= '0;
      dsp_b        <= '0;
      result       <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      done         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining  <= len;
              first_flag <= 1'b1;
            end else begin
              // Empty job completes immediately without touching the slice.
              result       <= '0;
              done         <= 1'b1;
              result_valid <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (beat) begin
            dsp_a      <= s_a;
            dsp_b      <= s_b;
            first_flag <= 1'b0;
            remaining  <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) drain_cnt <= DRN_W'(P_LAT + 1);
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - DRN_W'(1);
          if (drain_last) begin
            result       <= dsp_p;
            done         <= 1'b1;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the whole OPMODE delay line is reset so no stale ACC code reaches the slice after a mid-job reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= OPM_DLY; i++) opm_pipe[i] <= OPM_IDLE;
    end else begin
      opm_pipe[0] <= opm_line_in;
      for (int i = 1; i <= OPM_DLY; i++) opm_pipe[i] <= opm_pipe[i-1];
    end
  end

  assign dsp_opmode = opm_pipe[OPM_DLY];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice
// (A1/B1, M, OPMODE and P registers); expected results come from plain dot-product arithmetic.
module tb_dsp_mac_sequencer;

  localparam int LEN_W   = 8;
  localparam int OPM_DLY = 1;
  localparam int P_LAT   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, s_ready, dsp_ce, result_valid;
  logic              s_valid = 1'b0;
  logic [17:0]       s_a = '0, s_b = '0;
  logic [17:0]       dsp_a, dsp_b;
  logic [7:0]        dsp_opmode;
  logic [47:0]       result;

  // Behavioural slice state
  logic signed [17:0] a1 = '0, b1 = '0;
  logic signed [35:0] m_reg = '0;
  logic [7:0]         opm_r = '0;
  logic signed [47:0] p_reg = '0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int unsigned cyc = 0;
  logic [7:0]  opm_hist [0:4095];
  bit          ce_seen, busy_seen, ready_seen;
  int          done_cnt = 0;

  int          op_a [0:255];
  int          op_b [0:255];
  int unsigned bubble_q [$];
  int unsigned first_cyc;
  bit          ready_drop;

  // Job observations returned by run_job
  logic [47:0] j_res;
  int          j_lat, j_width;
  bit          j_tmo, j_busy_after;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .OPM_DLY(OPM_DLY), .P_LAT(P_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(p_reg), .result(result), .result_valid(result_valid)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DSP48A1: A1REG=B1REG=MREG=PREG=OPMODEREG=1, post-adder P = X + Z
  always @(posedge clk) begin
    if (dsp_ce) begin
      a1    <= dsp_a;
      b1    <= dsp_b;
      m_reg <= a1 * b1;
      opm_r <= dsp_opmode;
      p_reg <= ((opm_r[1:0] == 2'b01) ? {{12{m_reg[35]}}, m_reg} : 48'sd0)
             + ((opm_r[3:2] == 2'b10) ? p_reg : 48'sd0);
    end
  end

  always @(negedge clk) begin
    opm_hist[cyc[11:0]] = dsp_opmode;
    if (dsp_ce)  ce_seen = 1'b1;
    if (busy)    busy_seen = 1'b1;
    if (s_ready) ready_seen = 1'b1;
    if (done)    done_cnt++;
  end

  // Issue one job of n beats from op_a/op_b; gap_len bubbles before beat gap_at, optional random bubbles.
  task automatic run_job(input int n, input int gap_at, input int gap_len,
                         input bit rand_gaps, input bit mid_start);
    int beat = 0;
    int gaps;
    int wd;
    int unsigned k_last = 0;
    bubble_q.delete();
    ready_drop = 1'b0;
    j_tmo = 1'b0; j_lat = -1; j_width = 0; j_res = '0; j_busy_after = 1'b1;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    len   = LEN_W'($urandom);
    while (beat < n && !j_tmo) begin
      gaps = 0;
      if (beat == gap_at) gaps = gap_len;
      else if (rand_gaps) gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0;
        s_a = 18'($urandom);
        s_b = 18'($urandom);
        if (s_ready) bubble_q.push_back(cyc + 1);
        else ready_drop = 1'b1;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_a = 18'(op_a[beat]);
      s_b = 18'(op_b[beat]);
      start = (mid_start && beat == 1);
      len   = LEN_W'($urandom_range(1, 9));
      wd = 0;
      while (!s_ready && wd < 50) begin @(negedge clk); wd++; end
      if (!s_ready) j_tmo = 1'b1;
      else begin
        if (beat == 0) first_cyc = cyc + 1;
        k_last = cyc + 1;
        beat++;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
    wd = 0;
    while (!done && wd < 40) begin @(negedge clk); wd++; end
    if (!done) j_tmo = 1'b1;
    else begin
      j_lat = int'(cyc - k_last);
      j_res = result;
      while (done && j_width < 10) begin j_width++; @(negedge clk); end
      j_busy_after = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({busy, done, s_ready, dsp_ce, result_valid} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, s_ready, dsp_ce, result_valid}); else pass_cnt++;
    chk_cnt++; if ({dsp_a, dsp_b} !== 36'd0)
      $display("FAIL reset_ab: got %h expected 0", {dsp_a, dsp_b}); else pass_cnt++;
    chk_cnt++; if (result !== 48'd0)
      $display("FAIL reset_result: got %h expected 0", result); else pass_cnt++;
    chk_cnt++; if (dsp_opmode !== 8'h00)
      $display("FAIL reset_opmode: got %h expected 00", dsp_opmode); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin op_a[i] = i + 1; op_b[i] = i + 5; end
    run_job(4, -1, 0, 1'b0, 1'b0);
    chk_cnt++; if (j_tmo) $display("FAIL b2b_timeout: got timeout expected done"); else pass_cnt++;
    chk_cnt++; if (j_res !== 48'd70) $display("FAIL b2b_result: got %0d expected 70", $signed(j_res)); else pass_cnt++;
    chk_cnt++; if (j_lat != P_LAT + 1) $display("FAIL b2b_latency: got %0d expected %0d", j_lat, P_LAT + 1); else pass_cnt++;
    chk_cnt++; if (j_width != 1) $display("FAIL b2b_done_width: got %0d expected 1", j_width); else pass_cnt++;
    chk_cnt++; if (j_busy_after !== 1'b0) $display("FAIL b2b_busy_after: got %b expected 0", j_busy_after); else pass_cnt++;
    chk_cnt++; if (opm_hist[12'(first_cyc + OPM_DLY)] !== 8'h01)
      $display("FAIL b2b_first_opmode: got %h expected 01", opm_hist[12'(first_cyc + OPM_DLY)]); else pass_cnt++;
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 4; i++) begin op_a[i] = i + 1; op_b[i] = i + 5; end
    run_job(4, 2, 2, 1'b0, 1'b0);
    chk_cnt++; if (j_res !== 48'd70) $display("FAIL bubble_result: got %0d expected 70", $signed(j_res)); else pass_cnt++;
    chk_cnt++; if (ready_drop || bubble_q.size() != 2)
      $display("FAIL bubble_ready: got %0d ready bubble cycles expected 2", bubble_q.size()); else pass_cnt++;
    foreach (bubble_q[i]) begin
      chk_cnt++; if (opm_hist[12'(bubble_q[i] + OPM_DLY)] !== 8'h08)
        $display("FAIL bubble_opmode%0d: got %h expected 08", i, opm_hist[12'(bubble_q[i] + OPM_DLY)]); else pass_cnt++;
    end
  endtask

  task automatic test_signed();
    op_a[0] = -3; op_b[0] = 7;
    op_a[1] = 2;  op_b[1] = -5;
    run_job(2, -1, 0, 1'b0, 1'b0);
    chk_cnt++; if (j_res !== 48'hFFFF_FFFF_FFE1)
      $display("FAIL signed_result: got %h expected ffffffffffe1", j_res); else pass_cnt++;
  endtask

  task automatic test_mid_start();
    op_a[0] = 3; op_b[0] = 4;
    op_a[1] = 5; op_b[1] = 6;
    op_a[2] = 7; op_b[2] = 8;
    run_job(3, -1, 0, 1'b0, 1'b1);
    chk_cnt++; if (j_res !== 48'd98 || j_lat != P_LAT + 1)
      $display("FAIL midstart_result: got %0d lat %0d expected 98 lat %0d", $signed(j_res), j_lat, P_LAT + 1); else pass_cnt++;
    op_a[0] = 9; op_b[0] = 9;
    run_job(1, -1, 0, 1'b0, 1'b0);
    chk_cnt++; if (j_res !== 48'd81) $display("FAIL midstart_next: got %0d expected 81", $signed(j_res)); else pass_cnt++;
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    ce_seen = 1'b0; busy_seen = 1'b0; ready_seen = 1'b0;
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++; if ({done, result_valid} !== 2'b11)
      $display("FAIL len0_done: got %b expected 11", {done, result_valid}); else pass_cnt++;
    chk_cnt++; if (result !== 48'd0) $display("FAIL len0_result: got %h expected 0", result); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (done !== 1'b0) $display("FAIL len0_done_clear: got %b expected 0", done); else pass_cnt++;
    chk_cnt++; if ({ce_seen, busy_seen, ready_seen} !== 3'b000)
      $display("FAIL len0_quiet: got ce/busy/ready %b expected 000", {ce_seen, busy_seen, ready_seen}); else pass_cnt++;
  endtask

  task automatic test_rst_mid_job();
    int d0;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_a = 18'(i + 10);
      s_b = 18'(i + 20);
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++; if ({busy, s_ready, dsp_ce} !== 3'b000)
      $display("FAIL rst_mid_ctrl: got busy/ready/ce %b expected 000", {busy, s_ready, dsp_ce}); else pass_cnt++;
    chk_cnt++; if (dsp_opmode !== 8'h00) $display("FAIL rst_mid_opmode: got %h expected 00", dsp_opmode); else pass_cnt++;
    repeat (8) @(negedge clk);
    chk_cnt++; if (done_cnt != d0) $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - d0); else pass_cnt++;
    op_a[0] = 1; op_b[0] = 1;
    run_job(1, -1, 0, 1'b0, 1'b0);
    chk_cnt++; if (j_res !== 48'd1) $display("FAIL rst_mid_next: got %0d expected 1", $signed(j_res)); else pass_cnt++;
  endtask

  task automatic test_random();
    int     n;
    longint sum;
    logic [47:0] exp_res;
    for (int t = 0; t < 8; t++) begin
      n = (t == 0) ? 255 : $urandom_range(1, 12);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        op_a[i] = (t == 1 && i == 0) ? -131072 : int'($urandom_range(0, 262143)) - 131072;
        op_b[i] = (t == 1 && i == 0) ? -131072 : int'($urandom_range(0, 262143)) - 131072;
        sum += longint'(op_a[i]) * longint'(op_b[i]);
      end
      exp_res = 48'(sum);
      run_job(n, -1, 0, 1'b1, 1'b0);
      chk_cnt++; if (j_tmo || j_res !== exp_res || j_lat != P_LAT + 1 || j_width != 1)
        $display("FAIL random%0d: got %h lat %0d width %0d expected %h lat %0d width 1",
                 t, j_res, j_lat, j_width, exp_res, P_LAT + 1); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubble();
    test_signed();
    test_mid_start();
    test_len_zero();
    test_rst_mid_job();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
